// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer for the IF stage: stage-0 lookup drives the RAS
// strobes, stage 1 registers the hit and presents the predicted next-fetch target.
module btb_predictor #(
  parameter int BTB_NUM = 64,
  parameter int TAG_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_pc_i,
  output logic        ras_push_o,
  output logic [31:0] ras_push_addr_o,
  output logic        ras_pop_o,
  input  logic [31:0] ras_addr_i,
  output logic        pred_valid_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] upd_target_i,
  input  logic [1:0]  upd_type_i,
  input  logic        upd_taken_i
);
  localparam int IDX_W = $clog2(BTB_NUM);

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JUMP = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

  logic             r_valid  [BTB_NUM];
  logic [1:0]       r_ctr    [BTB_NUM];
  logic [TAG_W-1:0] r_tag    [BTB_NUM];
  logic [29:0]      r_target [BTB_NUM];
  br_type_e         r_type   [BTB_NUM];

  // Stage-0 lookup
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  br_type_e         w_type;

  assign w_idx  = fetch_pc_i[IDX_W+1:2];
  assign w_tag  = fetch_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign w_type = r_type[w_idx];
  assign w_hit  = fetch_valid_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & ~flush_i;

  assign ras_push_o      = w_hit & (w_type == BR_CALL);
  assign ras_pop_o       = w_hit & (w_type == BR_RET);
  assign ras_push_addr_o = fetch_pc_i + 32'd8;

  // Training from the resolved-branch interface
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  br_type_e         w_u_type;
  logic             w_same;
  logic             w_alloc;
  logic             w_train;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;

  assign w_u_idx   = upd_pc_i[IDX_W+1:2];
  assign w_u_tag   = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign w_u_type  = br_type_e'(upd_type_i);
  assign w_same    = upd_valid_i & r_valid[w_u_idx] & (r_tag[w_u_idx] == w_u_tag)
                   & (r_type[w_u_idx] == w_u_type);
  assign w_alloc   = upd_valid_i & ~w_same & upd_taken_i;
  assign w_train   = w_same & (w_u_type == BR_COND);
  assign w_ctr_cur = r_ctr[w_u_idx];

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    w_ctr_next = w_ctr_cur;
    if (upd_taken_i) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
    end
  end

  // NOTE: only valid and ctr need a reset value; tag/target/type sit in a
  // reset-less block so they can map onto plain RAM, since valid gates them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_NUM; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (w_alloc) begin
      r_valid[w_u_idx] <= 1'b1;
      r_ctr[w_u_idx]   <= 2'b10;
    end else if (w_train) begin
      r_ctr[w_u_idx] <= w_ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_type[w_u_idx]   <= w_u_type;
      r_target[w_u_idx] <= upd_target_i[31:2];
    end else if (w_same) begin
      r_target[w_u_idx] <= upd_target_i[31:2];
    end
  end

  // Stage 1
  logic        r_s1_valid;
  logic        r_s1_hit;
  br_type_e    r_s1_type;
  logic        r_s1_ctr1;
  logic [31:0] r_s1_target;
  logic        w_s1_taken;

  // NOTE: non-blocking assignments keep every stage-1 register sampling the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_hit    <= 1'b0;
      r_s1_type   <= BR_COND;
      r_s1_ctr1   <= 1'b0;
      r_s1_target <= 32'd0;
    end else begin
      r_s1_valid  <= fetch_valid_i & ~flush_i;
      r_s1_hit    <= w_hit;
      r_s1_type   <= w_type;
      r_s1_ctr1   <= r_ctr[w_idx][1];
      r_s1_target <= {r_target[w_idx], 2'b00};
    end
  end

  // A flush arriving while stage 1 holds data kills the prediction immediately.
  assign w_s1_taken    = r_s1_valid & r_s1_hit & ((r_s1_type != BR_COND) | r_s1_ctr1) & ~flush_i;
  assign pred_valid_o  = r_s1_valid & ~flush_i;
  assign pred_taken_o  = w_s1_taken;
  assign pred_target_o = !w_s1_taken          ? 32'd0 :
                         (r_s1_type == BR_RET) ? ras_addr_i : r_s1_target;

  logic w_unused;
  assign w_unused = ^{upd_pc_i[31:IDX_W+TAG_W+2], upd_pc_i[1:0], upd_target_i[1:0]};
endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: a table-level reference model plus directed
// scenarios with literal expectations.
module tb_btb_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_pc_i = '0;
  logic        ras_push_o;
  logic [31:0] ras_push_addr_o;
  logic        ras_pop_o;
  logic [31:0] ras_addr_i = '0;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic [31:0] upd_target_i = '0;
  logic [1:0]  upd_type_i = '0;
  logic        upd_taken_i = 1'b0;

  btb_predictor dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
    .ras_push_o(ras_push_o), .ras_push_addr_o(ras_push_addr_o), .ras_pop_o(ras_pop_o),
    .ras_addr_i(ras_addr_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
    .upd_type_i(upd_type_i), .upd_taken_i(upd_taken_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per slot, types as plain integers (0 cond .. 3 return)
  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    int          typ;
    int          ctr;
  } ent_t;

  ent_t        m_tab [64];
  bit          s1v, s1hit;
  int          s1typ, s1ctr;
  logic [31:0] s1tgt;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % 64;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> 8) % 4096;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int unsigned i = idx_of(pc);
    return fetch_valid_i && !flush_i && m_tab[i].v && (m_tab[i].tag == tag_of(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_tab[i].v   = 0;
      m_tab[i].ctr = 1;
    end
    s1v   = 0;
    s1hit = 0;
  endtask

  task automatic model_step();
    int unsigned i = idx_of(fetch_pc_i);
    int unsigned j = idx_of(upd_pc_i);
    s1hit = m_hit(fetch_pc_i);
    s1v   = fetch_valid_i && !flush_i;
    s1typ = m_tab[i].typ;
    s1ctr = m_tab[i].ctr;
    s1tgt = m_tab[i].tgt & 32'hFFFF_FFFC;
    if (upd_valid_i) begin
      if (m_tab[j].v && m_tab[j].tag == tag_of(upd_pc_i) && m_tab[j].typ == int'(upd_type_i)) begin
        m_tab[j].tgt = upd_target_i;
        if (m_tab[j].typ == 0) begin
          if (upd_taken_i) m_tab[j].ctr = (m_tab[j].ctr >= 3) ? 3 : m_tab[j].ctr + 1;
          else             m_tab[j].ctr = (m_tab[j].ctr <= 0) ? 0 : m_tab[j].ctr - 1;
        end
      end else if (upd_taken_i) begin
        m_tab[j] = '{v: 1, tag: tag_of(upd_pc_i), tgt: upd_target_i, typ: int'(upd_type_i), ctr: 2};
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        automatic int unsigned i  = idx_of(fetch_pc_i);
        automatic bit          h  = m_hit(fetch_pc_i);
        automatic bit          pv = s1v && !flush_i;
        automatic bit          pt = pv && s1hit && (s1typ != 0 || s1ctr >= 2);
        automatic logic [31:0] et = !pt ? 32'd0 : (s1typ == 3) ? ras_addr_i : s1tgt;
        check("model_push", {31'd0, ras_push_o}, {31'd0, h && m_tab[i].typ == 2});
        check("model_pop",  {31'd0, ras_pop_o},  {31'd0, h && m_tab[i].typ == 3});
        if (h && m_tab[i].typ == 2) check("model_push_addr", ras_push_addr_o, fetch_pc_i + 32'd8);
        check("model_pred_valid", {31'd0, pred_valid_o}, {31'd0, pv});
        check("model_pred_taken", {31'd0, pred_taken_o}, {31'd0, pt});
        check("model_pred_target", pred_target_o, et);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ,
                     input logic tk);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_target_i = tgt;
    upd_type_i   = typ;
    upd_taken_i  = tk;
    tick();
    upd_valid_i  = 1'b0;
  endtask

  // Fetch one PC, capture stage-0 strobes and the stage-1 prediction one cycle later
  task automatic lookup(input logic [31:0] pc, input logic fl,
                        output logic push, output logic pop, output logic [31:0] paddr,
                        output logic pv, output logic pt, output logic [31:0] ptgt);
    fetch_valid_i = 1'b1;
    fetch_pc_i    = pc;
    flush_i       = fl;
    @(negedge clk);
    push  = ras_push_o;
    pop   = ras_pop_o;
    paddr = ras_push_addr_o;
    tick();
    fetch_valid_i = 1'b0;
    flush_i       = 1'b0;
    @(negedge clk);
    pv   = pred_valid_o;
    pt   = pred_taken_o;
    ptgt = pred_target_o;
    tick();
  endtask

  logic        c_push, c_pop, c_pv, c_pt;
  logic [31:0] c_paddr, c_tgt;

  initial begin
    automatic logic [31:0] pcs [4] = '{32'h8000_0100, 32'h8000_0200, 32'h8000_2010, 32'hBFC0_0000};

    // Reset state
    #2;
    check("rst_pred_valid", {31'd0, pred_valid_o}, 32'd0);
    check("rst_pred_taken", {31'd0, pred_taken_o}, 32'd0);
    check("rst_pred_target", pred_target_o, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // 1: cold miss
    lookup(32'hBFC0_0000, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t1_push", {31'd0, c_push}, 32'd0);
    check("t1_pop", {31'd0, c_pop}, 32'd0);
    check("t1_valid", {31'd0, c_pv}, 32'd1);
    check("t1_taken", {31'd0, c_pt}, 32'd0);
    check("t1_target", c_tgt, 32'd0);

    // 2: call
    upd(32'h8000_0100, 32'h8000_2000, 2'b10, 1'b1);
    lookup(32'h8000_0100, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t2_push", {31'd0, c_push}, 32'd1);
    check("t2_push_addr", c_paddr, 32'h8000_0108);
    check("t2_taken", {31'd0, c_pt}, 32'd1);
    check("t2_target", c_tgt, 32'h8000_2000);

    // 3: return takes its target from the RAS
    ras_addr_i = 32'h8000_0108;
    upd(32'h8000_2010, 32'h0BAD_0000, 2'b11, 1'b1);
    lookup(32'h8000_2010, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t3_pop", {31'd0, c_pop}, 32'd1);
    check("t3_push", {31'd0, c_push}, 32'd0);
    check("t3_target", c_tgt, 32'h8000_0108);

    // 4: conditional counter training and saturation
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b1);
    lookup(32'h8000_0200, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t4_alloc_taken", {31'd0, c_pt}, 32'd1);
    check("t4_alloc_target", c_tgt, 32'h8000_0300);
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b0);
    lookup(32'h8000_0200, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t4_nt1_valid", {31'd0, c_pv}, 32'd1);
    check("t4_nt1_taken", {31'd0, c_pt}, 32'd0);
    check("t4_nt1_target", c_tgt, 32'd0);
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b0);
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b0);
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b1);
    lookup(32'h8000_0200, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t4_sat00_taken", {31'd0, c_pt}, 32'd0);
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b1);
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b1);
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b1);
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b0);
    lookup(32'h8000_0200, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t4_sat11_taken", {31'd0, c_pt}, 32'd1);
    upd(32'h8000_0200, 32'h8000_0300, 2'b00, 1'b0);
    lookup(32'h8000_0200, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t4_ctr01_taken", {31'd0, c_pt}, 32'd0);

    // 5: flush in stage 0, then flush while stage 1 holds a hit
    upd(32'h8000_0100, 32'h8000_2000, 2'b10, 1'b1);
    lookup(32'h8000_0100, 1'b1, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t5_flush_push", {31'd0, c_push}, 32'd0);
    check("t5_flush_valid", {31'd0, c_pv}, 32'd0);
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 32'h8000_0100;
    @(negedge clk);
    check("t5_s1_push", {31'd0, ras_push_o}, 32'd1);
    tick();
    fetch_valid_i = 1'b0;
    flush_i       = 1'b1;
    @(negedge clk);
    check("t5_s1_flush_valid", {31'd0, pred_valid_o}, 32'd0);
    check("t5_s1_flush_taken", {31'd0, pred_taken_o}, 32'd0);
    tick();
    flush_i = 1'b0;

    // 6: same-cycle update and lookup sees the old entry; aliasing eviction
    upd_valid_i   = 1'b1;
    upd_pc_i      = 32'h8000_0100;
    upd_target_i  = 32'h8000_3000;
    upd_type_i    = 2'b00;
    upd_taken_i   = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 32'h8000_0100;
    @(negedge clk);
    check("t6_old_push", {31'd0, ras_push_o}, 32'd1);
    tick();
    upd_valid_i   = 1'b0;
    fetch_valid_i = 1'b0;
    @(negedge clk);
    check("t6_old_target", pred_target_o, 32'h8000_2000);
    tick();
    lookup(32'h8000_0100, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t6_new_push", {31'd0, c_push}, 32'd0);
    check("t6_new_target", c_tgt, 32'h8000_3000);
    upd(32'h8000_0200, 32'h8000_4000, 2'b01, 1'b1);
    lookup(32'h8000_0100, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t6_evicted_taken", {31'd0, c_pt}, 32'd0);
    lookup(32'h8000_0200, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("t6_alias_target", c_tgt, 32'h8000_4000);

    // Back-to-back stream with interleaved training, checked by the model each cycle
    upd(32'h8000_0100, 32'h8000_2000, 2'b10, 1'b1);
    for (int k = 0; k < 40; k++) begin
      fetch_valid_i = (k % 5) != 4;
      fetch_pc_i    = pcs[$urandom_range(3, 0)];
      flush_i       = (k % 7) == 3;
      upd_valid_i   = (k % 3) == 0;
      upd_pc_i      = pcs[$urandom_range(3, 0)];
      upd_type_i    = 2'($urandom_range(3, 0));
      upd_taken_i   = (upd_type_i != 2'b00) ? 1'b1 : 1'($urandom_range(1, 0));
      upd_target_i  = $urandom & 32'hFFFF_FFFC;
      ras_addr_i    = $urandom;
      tick();
    end
    upd_valid_i   = 1'b0;
    flush_i       = 1'b0;

    // Asynchronous reset mid-stream
    upd(32'h8000_0200, 32'h8000_4000, 2'b01, 1'b1);
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 32'h8000_0200;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, pred_valid_o}, 32'd0);
    check("rst_mid_taken", {31'd0, pred_taken_o}, 32'd0);
    check("rst_mid_target", pred_target_o, 32'd0);
    check("rst_mid_push", {31'd0, ras_push_o}, 32'd0);
    fetch_valid_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    lookup(32'h8000_0200, 1'b0, c_push, c_pop, c_paddr, c_pv, c_pt, c_tgt);
    check("rst_post_valid", {31'd0, c_pv}, 32'd1);
    check("rst_post_taken", {31'd0, c_pt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
